regbank_cmd_sequencer: RTL and testbench
========================================

Name: regbank_cmd_sequencer

Overview:
- Command front-end that sits directly upstream of the 64 x 32-bit register bank (64 shift-capable registers with a 6-bit select).
- Accepts one command at a time over a valid/ready interface and translates it into the bank's cycle-level controls: load, shift_right/shift_left, reset, flush, output_enable, serial_in.
- Captures the bank's data_out or serial_out stream and returns one response per command over a second valid/ready interface.

Parameters:
ADDR_W, 6, register select width (64 registers)
DATA_W, 32, register data width
CNT_W, 5, shift count field width; count value 0 means DATA_W shifts

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  0 LOAD, 1 READ, 2 SHR, 3 SHL, 4 CLR, 5 FLUSH, 6-7 illegal
cmd_addr  input  ADDR_W  target register
cmd_data  input  DATA_W  LOAD data
cmd_cnt  input  CNT_W  shift count
cmd_fill  input  1  serial_in bit used during shifts
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_W  READ data or shift spill word; 0 for other ops
rsp_err  output  1  illegal opcode flag (see Optional Feature)
bank_reg_select  output  ADDR_W  to bank reg_select
bank_data_in  output  DATA_W  to bank data_in
bank_load  output  1  to bank load
bank_shift_right  output  1  to bank shift_right
bank_shift_left  output  1  to bank shift_left
bank_serial_in  output  1  to bank serial_in
bank_reset  output  1  to bank reset (active-high, selected register only)
bank_flush  output  1  to bank flush (all registers)
bank_output_enable  output  1  to bank output_enable
bank_data_out  input  DATA_W  from bank data_out, combinational read
bank_serial_out  input  1  from bank serial_out

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0 except cmd_ready, which is 1. Latched command and spill register cleared.
- States: IDLE, EXEC, SHIFT, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid: latch op/addr/data/cnt/fill, clear spill, go to EXEC (SHR/SHL go to SHIFT).
  - cmd_ready=0 in every other state, so commands never overlap.
- EXEC: one cycle. bank_reg_select=addr throughout EXEC/SHIFT. Per op:
  - LOAD: bank_load=1, bank_data_in=data.
  - READ: bank_output_enable=1; capture bank_data_out into spill at the cycle-ending edge.
  - CLR: bank_reset=1.
  - FLUSH: bank_flush=1.
  - Then go to RESP.
- SHIFT
  - Hold bank_shift_right (SHR) or bank_shift_left (SHL)=1, bank_output_enable=1, bank_serial_in=fill.
  - Remaining count loaded with cnt (0 -> DATA_W), decremented each cycle.
  - Each cycle: SHR spill <= {bank_serial_out, spill[31:1]}; SHL spill <= {spill[30:0], bank_serial_out}.
  - Leave to RESP on the cycle the count reaches 1. Exactly N shift cycles, N in 1..32.
- RESP
  - All bank_* strobes 0. rsp_valid=1, rsp_data=spill (0 for LOAD/CLR/FLUSH).
  - Held stable while rsp_ready=0.
  - On rsp_ready: go to IDLE; cmd_ready rises the following cycle.
- Latency from accept to rsp_valid: 2 cycles for non-shift ops, N+1 cycles for shifts.
- Only one bank strobe is ever asserted per cycle.
- bank_reg_select and bank_data_in are 0 in IDLE/RESP.
- Reset mid-command: command abandoned, no response, bank strobes drop asynchronously.

Optional Feature:
- Macro REGSEQ_ILLEGAL_OP_ERR_EN.
- Defined: ops 6-7 skip EXEC and go to RESP with rsp_err=1, rsp_data=0. rsp_err=0 for every legal op.
- Undefined: ops 6-7 are silent NOPs (EXEC with no strobes, response with rsp_data=0); rsp_err tied to 0.

Test Plan:
- Reset released, LOAD addr 5 data 0xDEADBEEF, then READ addr 5 -> bank_load high exactly 1 cycle with select 5; READ rsp_data=0xDEADBEEF, rsp_valid 2 cycles after accept.
- After the above, SHR addr 5 cnt 4 fill 0 -> 4 cycles of bank_shift_right; rsp_data=0xF0000000; subsequent READ 5 -> 0x0DEADBEE.
- LOAD addr 63 0x80000001, SHL cnt 0 fill 1 -> 32 shift cycles; rsp_data=0x80000001; READ 63 -> 0xFFFFFFFF.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready stays 0, no bank strobes; a new cmd_valid is not accepted until the cycle after the response handshake.
- LOAD regs 1,2 with nonzero values, CLR 1, READ 1/2 -> 0 and the original value; then FLUSH, READ 2 -> 0.
- reset pulsed low during the 3rd cycle of a 10-cycle SHR -> shift strobe drops immediately, no response, cmd_ready=1 after release; cmd_op 7 -> rsp_err=1 with macro defined, 0 without.

Source files
------------

// File: rtl/regbank_cmd_sequencer.sv
// Command front-end for the 64 x 32 shift-capable register bank: one command at a time in,
// one response out. Define REGSEQ_ILLEGAL_OP_ERR_EN to flag ops 6-7 with rsp_err.
module regbank_cmd_sequencer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic              cmd_fill,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bank_reg_select,
    output logic [DATA_W-1:0] bank_data_in,
    output logic              bank_load,
    output logic              bank_shift_right,
    output logic              bank_shift_left,
    output logic              bank_serial_in,
    output logic              bank_reset,
    output logic              bank_flush,
    output logic              bank_output_enable,
    input  logic [DATA_W-1:0] bank_data_out,
    input  logic              bank_serial_out
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_SHR   = 3'd2;
    localparam logic [2:0] OP_SHL   = 3'd3;
    localparam logic [2:0] OP_CLR   = 3'd4;
    localparam logic [2:0] OP_FLUSH = 3'd5;

    // One extra bit so a zero count field can hold the full DATA_W shift length
    localparam logic [CNT_W:0] FULL_CNT = (CNT_W + 1)'(DATA_W);

    state_t              state, state_nx;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [CNT_W:0]      rem_q;
    logic                fill_q;
    logic [DATA_W-1:0]   spill_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            spill_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        addr_q  <= cmd_addr;
                        data_q  <= cmd_data;
                        rem_q   <= (cmd_cnt == '0) ? FULL_CNT : {1'b0, cmd_cnt};
                        fill_q  <= cmd_fill;
                        spill_q <= '0;
                    end
                end
                EXEC: begin
                    if (op_q == OP_READ) spill_q <= bank_data_out;
                end
                SHIFT: begin
                    rem_q <= rem_q - 1'b1;
                    // Collect the bits falling off the register so the response holds the spilled word
                    if (op_q == OP_SHR) spill_q <= {bank_serial_out, spill_q[DATA_W-1:1]};
                    else                spill_q <= {spill_q[DATA_W-2:0], bank_serial_out};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx           = state;
        cmd_ready          = 1'b0;
        rsp_valid          = 1'b0;
        rsp_data           = '0;
        bank_reg_select    = '0;
        bank_data_in       = '0;
        bank_load          = 1'b0;
        bank_shift_right   = 1'b0;
        bank_shift_left    = 1'b0;
        bank_serial_in     = 1'b0;
        bank_reset         = 1'b0;
        bank_flush         = 1'b0;
        bank_output_enable = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op == OP_SHR || cmd_op == OP_SHL) state_nx = SHIFT;
`ifdef REGSEQ_ILLEGAL_OP_ERR_EN
                    else if (cmd_op[2] & cmd_op[1])      state_nx = RESP;
`endif
                    else                                  state_nx = EXEC;
                end
            end
            EXEC: begin
                bank_reg_select = addr_q;
                case (op_q)
                    OP_LOAD: begin
                        bank_load    = 1'b1;
                        bank_data_in = data_q;
                    end
                    OP_READ:  bank_output_enable = 1'b1;
                    OP_CLR:   bank_reset         = 1'b1;
                    OP_FLUSH: bank_flush         = 1'b1;
                    default: ;
                endcase
                state_nx = RESP;
            end
            SHIFT: begin
                bank_reg_select    = addr_q;
                bank_shift_right   = (op_q == OP_SHR);
                bank_shift_left    = (op_q == OP_SHL);
                bank_output_enable = 1'b1;
                bank_serial_in     = fill_q;
                if (rem_q == 1) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = spill_q;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef REGSEQ_ILLEGAL_OP_ERR_EN
    assign rsp_err = (state == RESP) && op_q[2] && op_q[1];
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_regbank_cmd_sequencer.sv
// Directed bench for regbank_cmd_sequencer with a behavioural 64 x 32 register bank attached.
module tb_regbank_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [4:0]  cmd_cnt;
    logic        cmd_fill;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [5:0]  bank_reg_select;
    logic [31:0] bank_data_in, bank_data_out;
    logic        bank_load, bank_shift_right, bank_shift_left, bank_serial_in;
    logic        bank_reset, bank_flush, bank_output_enable, bank_serial_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regbank_cmd_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bank_reg_select(bank_reg_select), .bank_data_in(bank_data_in), .bank_load(bank_load),
        .bank_shift_right(bank_shift_right), .bank_shift_left(bank_shift_left),
        .bank_serial_in(bank_serial_in), .bank_reset(bank_reset), .bank_flush(bank_flush),
        .bank_output_enable(bank_output_enable), .bank_data_out(bank_data_out),
        .bank_serial_out(bank_serial_out)
    );

    // Behavioural register bank
    logic [31:0] bank [64];
    always @(posedge clk) begin
        if (bank_flush) begin
            for (int i = 0; i < 64; i++) bank[i] <= '0;
        end else if (bank_reset) bank[bank_reg_select] <= '0;
        else if (bank_load) bank[bank_reg_select] <= bank_data_in;
        else if (bank_shift_right) bank[bank_reg_select] <= {bank_serial_in, bank[bank_reg_select][31:1]};
        else if (bank_shift_left)  bank[bank_reg_select] <= {bank[bank_reg_select][30:0], bank_serial_in};
    end
    assign bank_data_out   = bank_output_enable ? bank[bank_reg_select] : 32'h0;
    assign bank_serial_out = bank_shift_left ? bank[bank_reg_select][31] : bank[bank_reg_select][0];

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [4:0]  cnt;
        logic        fill;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {bank_load, bank_shift_right, bank_shift_left, bank_reset, bank_flush};
    endfunction

    // Present a command, wait for acceptance and for rsp_valid, check latency, strobes and response
    task automatic issue(input vec_t v, input string tag);
        int n, lat, strb, nshift, exp_lat, exp_strb;
        logic multi, selbad, exp_err;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr;
        cmd_data = v.data; cmd_cnt = v.cnt; cmd_fill = v.fill;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_accept"}, cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1; strb = 0; multi = 0; selbad = 0;
        while (!rsp_valid && lat < 60) begin
            strb += $countones(strobes());
            if ($countones(strobes()) > 1) multi = 1;
            if (strobes() != 0 && bank_reg_select != v.addr) selbad = 1;
            if (bank_load && bank_data_in != v.data) selbad = 1;
            @(posedge clk); #1; lat++;
        end
        nshift = (v.cnt == 0) ? 32 : int'(v.cnt);
        exp_err = 1'b0;
        if (v.op == 3'd2 || v.op == 3'd3) begin
            exp_lat = nshift + 1; exp_strb = nshift;
        end else if (v.op >= 3'd6) begin
            exp_strb = 0;
`ifdef REGSEQ_ILLEGAL_OP_ERR_EN
            exp_lat = 1; exp_err = 1'b1;
`else
            exp_lat = 2;
`endif
        end else begin
            exp_lat = 2; exp_strb = (v.op == 3'd1) ? 0 : 1;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_strobe_cycles"}, strb, exp_strb);
        chk({tag, "_one_strobe"}, multi, 0);
        chk({tag, "_select"}, selbad, 0);
        chk({tag, "_rsp_data"}, rsp_data, v.exp_rsp);
        chk({tag, "_rsp_err"}, rsp_err, exp_err);
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_idle_after"}, {cmd_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        logic stall_bad;
        vec_t v;
        reset = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0;
        cmd_cnt = 0; cmd_fill = 0; rsp_ready = 0;

        // op, addr, data, cnt, fill, expected rsp_data
        vecs[0]  = '{3'd0,  6'd5, 32'hDEADBEEF, 5'd0,  1'b0, 32'h0};
        vecs[1]  = '{3'd1,  6'd5, 32'h0,        5'd0,  1'b0, 32'hDEADBEEF};
        vecs[2]  = '{3'd2,  6'd5, 32'h0,        5'd4,  1'b0, 32'hF0000000};
        vecs[3]  = '{3'd1,  6'd5, 32'h0,        5'd0,  1'b0, 32'h0DEADBEE};
        vecs[4]  = '{3'd0, 6'd63, 32'h80000001, 5'd0,  1'b0, 32'h0};
        vecs[5]  = '{3'd3, 6'd63, 32'h0,        5'd0,  1'b1, 32'h80000001};
        vecs[6]  = '{3'd1, 6'd63, 32'h0,        5'd0,  1'b0, 32'hFFFFFFFF};
        vecs[7]  = '{3'd0,  6'd1, 32'h12345678, 5'd0,  1'b0, 32'h0};
        vecs[8]  = '{3'd0,  6'd2, 32'hA5A5A5A5, 5'd0,  1'b0, 32'h0};
        vecs[9]  = '{3'd4,  6'd1, 32'h0,        5'd0,  1'b0, 32'h0};
        vecs[10] = '{3'd1,  6'd1, 32'h0,        5'd0,  1'b0, 32'h0};
        vecs[11] = '{3'd1,  6'd2, 32'h0,        5'd0,  1'b0, 32'hA5A5A5A5};
        vecs[12] = '{3'd5,  6'd0, 32'h0,        5'd0,  1'b0, 32'h0};
        vecs[13] = '{3'd1,  6'd2, 32'h0,        5'd0,  1'b0, 32'h0};
        vecs[14] = '{3'd0,  6'd3, 32'h0000000F, 5'd0,  1'b0, 32'h0};
        vecs[15] = '{3'd2,  6'd3, 32'h0,        5'd1,  1'b1, 32'h80000000};
        vecs[16] = '{3'd1,  6'd3, 32'h0,        5'd0,  1'b0, 32'h80000007};
        vecs[17] = '{3'd7,  6'd9, 32'h0,        5'd0,  1'b0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_valid", {cmd_ready, rsp_valid, rsp_err}, 3'b100);
        chk("reset_strobes", {strobes(), bank_output_enable, bank_serial_in}, 0);
        chk("reset_sel_data", {bank_reg_select, bank_data_in}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i], $sformatf("v%0d", i));
            handshake($sformatf("v%0d", i));
        end

        // Response stall with a queued command waiting on cmd_valid
        v = '{3'd0, 6'd10, 32'h13579BDF, 5'd0, 1'b0, 32'h0};
        issue(v, "st_load"); handshake("st_load");
        v = '{3'd1, 6'd10, 32'h0, 5'd0, 1'b0, 32'h13579BDF};
        issue(v, "st_read");
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 6'd10;
        stall_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data != 32'h13579BDF || cmd_ready ||
                strobes() != 0 || bank_output_enable) stall_bad = 1'b1;
        end
        chk("stall_stable", stall_bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("stall_not_yet_accepted", {cmd_ready, bank_output_enable, rsp_valid}, 3'b100);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("stall_next_exec", {cmd_ready, bank_output_enable}, 2'b01);
        @(posedge clk); #1;
        chk("stall_next_rsp", {rsp_valid, rsp_data}, {1'b1, 32'h13579BDF});
        handshake("stall_next");

        // Reset during the third cycle of a 10-cycle SHR
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_addr = 6'd5; cmd_cnt = 5'd10; cmd_fill = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rst_shift_running", bank_shift_right, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_strobe_drop", {bank_shift_right, bank_output_enable, rsp_valid}, 0);
        chk("rst_ready", cmd_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        stall_bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (rsp_valid || !cmd_ready || strobes() != 0) stall_bad = 1'b1;
        end
        chk("rst_no_response", stall_bad, 0);

        v = '{3'd6, 6'd4, 32'h0, 5'd0, 1'b0, 32'h0};
        issue(v, "op6_after_rst"); handshake("op6_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
